spi_ram_rw: RTL and testbench



---
 rtl/spi_ram_rw.sv | 139 +++++++++++++
 tb/tb_spi_ram_rw.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_rw.sv
// spi_ram_rw: SPI-side RAM access controller.
// Command bytes (dc_i=0) control the CPU reset and select an IRAM/DRAM read or
// write mode. Data bytes (dc_i=1) advance a byte address counter and, in the
// write modes, raise a one-cycle one-hot byte enable. RAM data never passes
// through this block.
//
// Ports
//   clk_i             system clock
//   rst_n_i           asynchronous active-low reset
//   dc_i              0 = command byte, 1 = data byte
//   spi_byte_vld_i    one-cycle strobe qualifying spi_byte_data_i
//   spi_byte_data_i   received SPI byte
//   cpu_rst_n_o       active-low CPU reset (held low out of reset)
//   iram_wr_sel_o     IRAM write mode
//   iram_rd_sel_o     IRAM read mode
//   dram_wr_sel_o     DRAM write mode
//   dram_rd_sel_o     DRAM read mode
//   ram_rw_addr_o     current byte address (XLEN bits, wraps)
//   ram_wr_byte_en_o  per-byte write enable pulse, one-hot on addr[1:0]
module spi_ram_rw #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            dc_i,
  input  logic            spi_byte_vld_i,
  input  logic [7:0]      spi_byte_data_i,
  output logic            cpu_rst_n_o,
  output logic            iram_wr_sel_o,
  output logic            iram_rd_sel_o,
  output logic            dram_wr_sel_o,
  output logic            dram_rd_sel_o,
  output logic [XLEN-1:0] ram_rw_addr_o,
  output logic [3:0]      ram_wr_byte_en_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    IRAM_WR = 3'd1,
    IRAM_RD = 3'd2,
    DRAM_WR = 3'd3,
    DRAM_RD = 3'd4
  } mode_t;

  localparam logic [7:0] CMD_CPU_RST = 8'h2a;
  localparam logic [7:0] CMD_CPU_RUN = 8'h2b;
  localparam logic [7:0] CMD_IRAM_WR = 8'h2c;
  localparam logic [7:0] CMD_IRAM_RD = 8'h2d;
  localparam logic [7:0] CMD_DRAM_WR = 8'h2e;
  localparam logic [7:0] CMD_DRAM_RD = 8'h2f;

  mode_t            mode;
  mode_t            mode_nxt;
  logic             wr_pend;
  logic [XLEN-1:0]  addr_eff;
  logic             cmd_vld;
  logic             dat_vld;

  // {iram_wr, iram_rd, dram_wr, dram_rd}
  function automatic logic [3:0] sel_of(input mode_t m);
    case (m)
      IRAM_WR: sel_of = 4'b1000;
      IRAM_RD: sel_of = 4'b0100;
      DRAM_WR: sel_of = 4'b0010;
      DRAM_RD: sel_of = 4'b0001;
      default: sel_of = 4'b0000;
    endcase
  endfunction

  assign cmd_vld = spi_byte_vld_i & ~dc_i;
  assign dat_vld = spi_byte_vld_i &  dc_i;

  // A write pulse defers its address increment by one cycle so RAM sees the
  // enable together with the address it was computed from. Any data byte that
  // arrives while that increment is still pending is handled on the
  // already-incremented address, so no byte is lost.
  always_comb begin
    addr_eff = wr_pend ? ram_rw_addr_o + XLEN'(1) : ram_rw_addr_o;
  end

  always_comb begin
    mode_nxt = mode;
    if (cmd_vld) begin
      case (spi_byte_data_i)
        CMD_IRAM_WR: mode_nxt = IRAM_WR;
        CMD_IRAM_RD: mode_nxt = IRAM_RD;
        CMD_DRAM_WR: mode_nxt = DRAM_WR;
        CMD_DRAM_RD: mode_nxt = DRAM_RD;
        default:     mode_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mode             <= IDLE;
      wr_pend          <= 1'b0;
      cpu_rst_n_o      <= 1'b0;
      iram_wr_sel_o    <= 1'b0;
      iram_rd_sel_o    <= 1'b0;
      dram_wr_sel_o    <= 1'b0;
      dram_rd_sel_o    <= 1'b0;
      ram_rw_addr_o    <= '0;
      ram_wr_byte_en_o <= 4'b0000;
    end else begin
      mode <= mode_nxt;
      {iram_wr_sel_o, iram_rd_sel_o, dram_wr_sel_o, dram_rd_sel_o} <= sel_of(mode_nxt);

      // Retire the pending write increment; later assignments may override.
      if (wr_pend) begin
        ram_rw_addr_o    <= addr_eff;
        ram_wr_byte_en_o <= 4'b0000;
        wr_pend          <= 1'b0;
      end

      if (cmd_vld) begin
        // Command clear wins over a pending increment.
        ram_rw_addr_o    <= '0;
        ram_wr_byte_en_o <= 4'b0000;
        wr_pend          <= 1'b0;
        if (spi_byte_data_i == CMD_CPU_RST) cpu_rst_n_o <= 1'b0;
        if (spi_byte_data_i == CMD_CPU_RUN) cpu_rst_n_o <= 1'b1;
      end else if (dat_vld) begin
        case (mode)
          IRAM_WR, DRAM_WR: begin
            ram_rw_addr_o    <= addr_eff;
            ram_wr_byte_en_o <= 4'b0001 << addr_eff[1:0];
            wr_pend          <= 1'b1;
          end
          IRAM_RD, DRAM_RD: begin
            ram_rw_addr_o <= addr_eff + XLEN'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_rw.sv
module tb_spi_ram_rw;

  localparam int XLEN = 32;

  logic            clk_i = 1'b0;
  logic            rst_n_i;
  logic            dc_i;
  logic            spi_byte_vld_i;
  logic [7:0]      spi_byte_data_i;
  logic            cpu_rst_n_o;
  logic            iram_wr_sel_o;
  logic            iram_rd_sel_o;
  logic            dram_wr_sel_o;
  logic            dram_rd_sel_o;
  logic [XLEN-1:0] ram_rw_addr_o;
  logic [3:0]      ram_wr_byte_en_o;

  int errors = 0;
  int checks = 0;

  spi_ram_rw #(.XLEN(XLEN)) dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .dc_i             (dc_i),
    .spi_byte_vld_i   (spi_byte_vld_i),
    .spi_byte_data_i  (spi_byte_data_i),
    .cpu_rst_n_o      (cpu_rst_n_o),
    .iram_wr_sel_o    (iram_wr_sel_o),
    .iram_rd_sel_o    (iram_rd_sel_o),
    .dram_wr_sel_o    (dram_wr_sel_o),
    .dram_rd_sel_o    (dram_rd_sel_o),
    .ram_rw_addr_o    (ram_rw_addr_o),
    .ram_wr_byte_en_o (ram_wr_byte_en_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [3:0] sels();
    return {iram_wr_sel_o, iram_rd_sel_o, dram_wr_sel_o, dram_rd_sel_o};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte for one clock; returns 1ns after the sampling edge.
  task automatic send(input logic dc, input logic [7:0] d);
    @(posedge clk_i); #1;
    dc_i = dc; spi_byte_data_i = d; spi_byte_vld_i = 1'b1;
    @(posedge clk_i); #1;
    spi_byte_vld_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // 32 write bytes, 9 clocks apart, checking pulse and deferred increment.
  task automatic wr_burst(input string tag, input logic [3:0] exp_sel);
    for (int i = 0; i < 32; i++) begin
      send(1'b1, 8'(i));
      chk({tag, "_ben"},  ram_wr_byte_en_o, 4'b0001 << (i % 4));
      chk({tag, "_addr"}, ram_rw_addr_o, i);
      chk({tag, "_sel"},  sels(), exp_sel);
      idle(1);
      chk({tag, "_ben0"}, ram_wr_byte_en_o, 4'b0000);
      chk({tag, "_inc"},  ram_rw_addr_o, i + 1);
      idle(6);
    end
    chk({tag, "_end"}, ram_rw_addr_o, 32);
  endtask

  task automatic rd_burst(input string tag, input logic [3:0] exp_sel);
    for (int i = 0; i < 32; i++) begin
      send(1'b1, 8'hff);
      chk({tag, "_ben"},  ram_wr_byte_en_o, 4'b0000);
      chk({tag, "_addr"}, ram_rw_addr_o, i + 1);
      chk({tag, "_sel"},  sels(), exp_sel);
      idle(7);
    end
    chk({tag, "_end"}, ram_rw_addr_o, 32);
  endtask

  initial begin
    rst_n_i = 1'b0; dc_i = 1'b0; spi_byte_vld_i = 1'b0; spi_byte_data_i = 8'h00;
    idle(3);
    chk("rst_cpu",  cpu_rst_n_o, 1'b0);
    chk("rst_sel",  sels(), 4'b0000);
    chk("rst_addr", ram_rw_addr_o, 0);
    chk("rst_ben",  ram_wr_byte_en_o, 4'b0000);
    @(negedge clk_i); rst_n_i = 1'b1;
    idle(2);

    send(1'b0, 8'h2a);
    chk("cpurst_cpu", cpu_rst_n_o, 1'b0);
    chk("cpurst_sel", sels(), 4'b0000);
    send(1'b0, 8'h2b);
    chk("cpurun_cpu", cpu_rst_n_o, 1'b1);
    chk("cpurun_sel", sels(), 4'b0000);

    // Data byte in IDLE is ignored.
    send(1'b1, 8'h55);
    chk("idle_ben",  ram_wr_byte_en_o, 4'b0000);
    chk("idle_addr", ram_rw_addr_o, 0);

    send(1'b0, 8'h2c);
    chk("iwr_cmd_sel",  sels(), 4'b1000);
    chk("iwr_cmd_addr", ram_rw_addr_o, 0);
    wr_burst("iwr", 4'b1000);

    // vld low: junk on dc/data changes nothing.
    dc_i = 1'b0; spi_byte_data_i = 8'h2a;
    idle(3);
    chk("novld_addr", ram_rw_addr_o, 32);
    chk("novld_cpu",  cpu_rst_n_o, 1'b1);
    chk("novld_sel",  sels(), 4'b1000);

    send(1'b0, 8'h2d);
    chk("ird_cmd_sel",  sels(), 4'b0100);
    chk("ird_cmd_addr", ram_rw_addr_o, 0);
    rd_burst("ird", 4'b0100);

    send(1'b0, 8'h2e);
    chk("dwr_cmd_sel",  sels(), 4'b0010);
    chk("dwr_cmd_addr", ram_rw_addr_o, 0);
    wr_burst("dwr", 4'b0010);

    send(1'b0, 8'h2f);
    chk("drd_cmd_sel",  sels(), 4'b0001);
    chk("drd_cmd_addr", ram_rw_addr_o, 0);
    chk("drd_cpu",      cpu_rst_n_o, 1'b1);
    rd_burst("drd", 4'b0001);

    // Unknown command while in DRAM_WR.
    send(1'b0, 8'h2e);
    send(1'b1, 8'h11); idle(4);
    send(1'b1, 8'h22); idle(4);
    chk("unk_pre_addr", ram_rw_addr_o, 2);
    send(1'b0, 8'h00);
    chk("unk_sel",  sels(), 4'b0000);
    chk("unk_addr", ram_rw_addr_o, 0);
    chk("unk_cpu",  cpu_rst_n_o, 1'b1);
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 8'(i));
      chk("unk_ben",  ram_wr_byte_en_o, 4'b0000);
      chk("unk_daddr", ram_rw_addr_o, 0);
      idle(4);
    end

    // Command in the cycle right after a write pulse: clear wins.
    send(1'b0, 8'h2c);
    send(1'b1, 8'h01); idle(4);
    send(1'b1, 8'h02);
    chk("race_ben", ram_wr_byte_en_o, 4'b0010);
    chk("race_addr_pre", ram_rw_addr_o, 1);
    dc_i = 1'b0; spi_byte_data_i = 8'h2e; spi_byte_vld_i = 1'b1;
    @(posedge clk_i); #1;
    spi_byte_vld_i = 1'b0;
    chk("race_addr", ram_rw_addr_o, 0);
    chk("race_ben0", ram_wr_byte_en_o, 4'b0000);
    chk("race_sel",  sels(), 4'b0010);
    idle(3);
    chk("race_hold", ram_rw_addr_o, 0);

    // Asynchronous reset in the middle of a write pulse.
    send(1'b1, 8'h10); idle(4);
    send(1'b1, 8'h20);
    chk("arst_pre_ben", ram_wr_byte_en_o, 4'b0010);
    #2 rst_n_i = 1'b0;
    #1;
    chk("arst_ben",  ram_wr_byte_en_o, 4'b0000);
    chk("arst_addr", ram_rw_addr_o, 0);
    chk("arst_sel",  sels(), 4'b0000);
    chk("arst_cpu",  cpu_rst_n_o, 1'b0);
    @(negedge clk_i); rst_n_i = 1'b1;
    send(1'b1, 8'h30);
    chk("post_rst_ben",  ram_wr_byte_en_o, 4'b0000);
    chk("post_rst_addr", ram_rw_addr_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
